// File: rtl/sdram_axi_arbiter.sv
// Two-master AXI4 arbiter in front of the SDRAM slave port.
// One whole transaction (read or write) is granted at a time using round-robin
// over four request slots; payloads pass through combinationally under the grant.
module sdram_axi_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) (
    input  logic                clock,
    input  logic                reset,
    // master 0
    input  logic                in0_awvalid,
    input  logic [ADDR_W-1:0]   in0_awaddr,
    input  logic [ID_W-1:0]     in0_awid,
    input  logic [7:0]          in0_awlen,
    input  logic [2:0]          in0_awsize,
    input  logic [1:0]          in0_awburst,
    output logic                in0_awready,
    input  logic                in0_wvalid,
    input  logic [DATA_W-1:0]   in0_wdata,
    input  logic [DATA_W/8-1:0] in0_wstrb,
    input  logic                in0_wlast,
    output logic                in0_wready,
    input  logic                in0_bready,
    output logic                in0_bvalid,
    output logic [1:0]          in0_bresp,
    output logic [ID_W-1:0]     in0_bid,
    input  logic                in0_arvalid,
    input  logic [ADDR_W-1:0]   in0_araddr,
    input  logic [ID_W-1:0]     in0_arid,
    input  logic [7:0]          in0_arlen,
    input  logic [2:0]          in0_arsize,
    input  logic [1:0]          in0_arburst,
    output logic                in0_arready,
    input  logic                in0_rready,
    output logic                in0_rvalid,
    output logic [DATA_W-1:0]   in0_rdata,
    output logic [1:0]          in0_rresp,
    output logic                in0_rlast,
    output logic [ID_W-1:0]     in0_rid,
    // master 1
    input  logic                in1_awvalid,
    input  logic [ADDR_W-1:0]   in1_awaddr,
    input  logic [ID_W-1:0]     in1_awid,
    input  logic [7:0]          in1_awlen,
    input  logic [2:0]          in1_awsize,
    input  logic [1:0]          in1_awburst,
    output logic                in1_awready,
    input  logic                in1_wvalid,
    input  logic [DATA_W-1:0]   in1_wdata,
    input  logic [DATA_W/8-1:0] in1_wstrb,
    input  logic                in1_wlast,
    output logic                in1_wready,
    input  logic                in1_bready,
    output logic                in1_bvalid,
    output logic [1:0]          in1_bresp,
    output logic [ID_W-1:0]     in1_bid,
    input  logic                in1_arvalid,
    input  logic [ADDR_W-1:0]   in1_araddr,
    input  logic [ID_W-1:0]     in1_arid,
    input  logic [7:0]          in1_arlen,
    input  logic [2:0]          in1_arsize,
    input  logic [1:0]          in1_arburst,
    output logic                in1_arready,
    input  logic                in1_rready,
    output logic                in1_rvalid,
    output logic [DATA_W-1:0]   in1_rdata,
    output logic [1:0]          in1_rresp,
    output logic                in1_rlast,
    output logic [ID_W-1:0]     in1_rid,
    // SDRAM slave side
    output logic                out_awvalid,
    output logic [ADDR_W-1:0]   out_awaddr,
    output logic [ID_W-1:0]     out_awid,
    output logic [7:0]          out_awlen,
    output logic [2:0]          out_awsize,
    output logic [1:0]          out_awburst,
    input  logic                out_awready,
    output logic                out_wvalid,
    output logic [DATA_W-1:0]   out_wdata,
    output logic [DATA_W/8-1:0] out_wstrb,
    output logic                out_wlast,
    input  logic                out_wready,
    output logic                out_bready,
    input  logic                out_bvalid,
    input  logic [1:0]          out_bresp,
    input  logic [ID_W-1:0]     out_bid,
    output logic                out_arvalid,
    output logic [ADDR_W-1:0]   out_araddr,
    output logic [ID_W-1:0]     out_arid,
    output logic [7:0]          out_arlen,
    output logic [2:0]          out_arsize,
    output logic [1:0]          out_arburst,
    input  logic                out_arready,
    output logic                out_rready,
    input  logic                out_rvalid,
    input  logic [DATA_W-1:0]   out_rdata,
    input  logic [1:0]          out_rresp,
    input  logic                out_rlast,
    input  logic [ID_W-1:0]     out_rid
);

    typedef enum logic [2:0] {IDLE, AR_FWD, R_DATA, AW_FWD, W_DATA, B_RESP} state_t;

    state_t      state, state_next;
    logic        gnt, gnt_next;     // granted master index
    logic [1:0]  rr, rr_next;       // highest-priority slot
    logic [3:0]  req;
    logic [1:0]  win, idx;
    logic        found;

    logic sel_awvalid, sel_wvalid, sel_wlast, sel_bready, sel_arvalid, sel_rready;

    // slot order S0=in0 AW, S1=in0 AR, S2=in1 AW, S3=in1 AR
    assign req = {in1_arvalid, in1_awvalid, in0_arvalid, in0_awvalid};

    assign sel_awvalid = gnt ? in1_awvalid : in0_awvalid;
    assign sel_wvalid  = gnt ? in1_wvalid  : in0_wvalid;
    assign sel_wlast   = gnt ? in1_wlast   : in0_wlast;
    assign sel_bready  = gnt ? in1_bready  : in0_bready;
    assign sel_arvalid = gnt ? in1_arvalid : in0_arvalid;
    assign sel_rready  = gnt ? in1_rready  : in0_rready;

    // downstream payload always follows the current grant
    assign out_awaddr  = gnt ? in1_awaddr  : in0_awaddr;
    assign out_awid    = gnt ? in1_awid    : in0_awid;
    assign out_awlen   = gnt ? in1_awlen   : in0_awlen;
    assign out_awsize  = gnt ? in1_awsize  : in0_awsize;
    assign out_awburst = gnt ? in1_awburst : in0_awburst;
    assign out_wdata   = gnt ? in1_wdata   : in0_wdata;
    assign out_wstrb   = gnt ? in1_wstrb   : in0_wstrb;
    assign out_wlast   = sel_wlast;
    assign out_araddr  = gnt ? in1_araddr  : in0_araddr;
    assign out_arid    = gnt ? in1_arid    : in0_arid;
    assign out_arlen   = gnt ? in1_arlen   : in0_arlen;
    assign out_arsize  = gnt ? in1_arsize  : in0_arsize;
    assign out_arburst = gnt ? in1_arburst : in0_arburst;

    // response payloads are broadcast; only the valid is steered
    assign in0_bresp = out_bresp;
    assign in0_bid   = out_bid;
    assign in1_bresp = out_bresp;
    assign in1_bid   = out_bid;
    assign in0_rdata = out_rdata;
    assign in0_rresp = out_rresp;
    assign in0_rlast = out_rlast;
    assign in0_rid   = out_rid;
    assign in1_rdata = out_rdata;
    assign in1_rresp = out_rresp;
    assign in1_rlast = out_rlast;
    assign in1_rid   = out_rid;

    // round-robin search starting at rr
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = rr + 2'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // state, grant and pointer registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= 1'b0;
            rr    <= '0;
        end else begin
            state <= state_next;
            gnt   <= gnt_next;
            rr    <= rr_next;
        end
    end

    // next-state, grant capture and pointer update
    always_comb begin
        state_next = state;
        gnt_next   = gnt;
        rr_next    = rr;
        case (state)
            IDLE: if (found) begin
                gnt_next   = win[1];
                rr_next    = win + 2'd1;
                state_next = win[0] ? AR_FWD : AW_FWD;
            end
            AR_FWD: if (sel_arvalid && out_arready) state_next = R_DATA;
            R_DATA: if (out_rvalid && sel_rready && out_rlast) state_next = IDLE;
            AW_FWD: if (sel_awvalid && out_awready) state_next = W_DATA;
            W_DATA: if (sel_wvalid && out_wready && sel_wlast) state_next = B_RESP;
            B_RESP: if (out_bvalid && sel_bready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // handshake steering: only the granted master sees ready/valid, only in its phase
    always_comb begin
        out_awvalid = 1'b0;
        out_wvalid  = 1'b0;
        out_bready  = 1'b0;
        out_arvalid = 1'b0;
        out_rready  = 1'b0;
        in0_awready = 1'b0;
        in0_wready  = 1'b0;
        in0_bvalid  = 1'b0;
        in0_arready = 1'b0;
        in0_rvalid  = 1'b0;
        in1_awready = 1'b0;
        in1_wready  = 1'b0;
        in1_bvalid  = 1'b0;
        in1_arready = 1'b0;
        in1_rvalid  = 1'b0;
        case (state)
            AR_FWD: begin
                out_arvalid = sel_arvalid;
                in0_arready = !gnt && out_arready;
                in1_arready = gnt && out_arready;
            end
            R_DATA: begin
                out_rready = sel_rready;
                in0_rvalid = !gnt && out_rvalid;
                in1_rvalid = gnt && out_rvalid;
            end
            AW_FWD: begin
                out_awvalid = sel_awvalid;
                in0_awready = !gnt && out_awready;
                in1_awready = gnt && out_awready;
            end
            W_DATA: begin
                out_wvalid = sel_wvalid;
                in0_wready = !gnt && out_wready;
                in1_wready = gnt && out_wready;
            end
            B_RESP: begin
                out_bready = sel_bready;
                in0_bvalid = !gnt && out_bvalid;
                in1_bvalid = gnt && out_bvalid;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_axi_arbiter.sv
// Self-checking bench for sdram_axi_arbiter: a cycle-vector table of handshake
// signals plus directed sequences for payload routing, fairness and reset.
module tb_sdram_axi_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int ID_W   = 4;

    logic clock = 1'b0;
    logic reset;

    logic in0_awvalid, in0_awready, in0_wvalid, in0_wlast, in0_wready, in0_bready, in0_bvalid;
    logic in0_arvalid, in0_arready, in0_rready, in0_rvalid, in0_rlast;
    logic [ADDR_W-1:0] in0_awaddr, in0_araddr;
    logic [ID_W-1:0] in0_awid, in0_arid, in0_bid, in0_rid;
    logic [7:0] in0_awlen, in0_arlen;
    logic [2:0] in0_awsize, in0_arsize;
    logic [1:0] in0_awburst, in0_arburst, in0_bresp, in0_rresp;
    logic [DATA_W-1:0] in0_wdata, in0_rdata;
    logic [DATA_W/8-1:0] in0_wstrb;

    logic in1_awvalid, in1_awready, in1_wvalid, in1_wlast, in1_wready, in1_bready, in1_bvalid;
    logic in1_arvalid, in1_arready, in1_rready, in1_rvalid, in1_rlast;
    logic [ADDR_W-1:0] in1_awaddr, in1_araddr;
    logic [ID_W-1:0] in1_awid, in1_arid, in1_bid, in1_rid;
    logic [7:0] in1_awlen, in1_arlen;
    logic [2:0] in1_awsize, in1_arsize;
    logic [1:0] in1_awburst, in1_arburst, in1_bresp, in1_rresp;
    logic [DATA_W-1:0] in1_wdata, in1_rdata;
    logic [DATA_W/8-1:0] in1_wstrb;

    logic out_awvalid, out_awready, out_wvalid, out_wlast, out_wready, out_bready, out_bvalid;
    logic out_arvalid, out_arready, out_rready, out_rvalid, out_rlast;
    logic [ADDR_W-1:0] out_awaddr, out_araddr;
    logic [ID_W-1:0] out_awid, out_arid, out_bid, out_rid;
    logic [7:0] out_awlen, out_arlen;
    logic [2:0] out_awsize, out_arsize;
    logic [1:0] out_awburst, out_arburst, out_bresp, out_rresp;
    logic [DATA_W-1:0] out_wdata, out_rdata;
    logic [DATA_W/8-1:0] out_wstrb;

    int checks = 0;
    int errors = 0;

    sdram_axi_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clock(clock), .reset(reset),
        .in0_awvalid(in0_awvalid), .in0_awaddr(in0_awaddr), .in0_awid(in0_awid),
        .in0_awlen(in0_awlen), .in0_awsize(in0_awsize), .in0_awburst(in0_awburst),
        .in0_awready(in0_awready), .in0_wvalid(in0_wvalid), .in0_wdata(in0_wdata),
        .in0_wstrb(in0_wstrb), .in0_wlast(in0_wlast), .in0_wready(in0_wready),
        .in0_bready(in0_bready), .in0_bvalid(in0_bvalid), .in0_bresp(in0_bresp), .in0_bid(in0_bid),
        .in0_arvalid(in0_arvalid), .in0_araddr(in0_araddr), .in0_arid(in0_arid),
        .in0_arlen(in0_arlen), .in0_arsize(in0_arsize), .in0_arburst(in0_arburst),
        .in0_arready(in0_arready), .in0_rready(in0_rready), .in0_rvalid(in0_rvalid),
        .in0_rdata(in0_rdata), .in0_rresp(in0_rresp), .in0_rlast(in0_rlast), .in0_rid(in0_rid),
        .in1_awvalid(in1_awvalid), .in1_awaddr(in1_awaddr), .in1_awid(in1_awid),
        .in1_awlen(in1_awlen), .in1_awsize(in1_awsize), .in1_awburst(in1_awburst),
        .in1_awready(in1_awready), .in1_wvalid(in1_wvalid), .in1_wdata(in1_wdata),
        .in1_wstrb(in1_wstrb), .in1_wlast(in1_wlast), .in1_wready(in1_wready),
        .in1_bready(in1_bready), .in1_bvalid(in1_bvalid), .in1_bresp(in1_bresp), .in1_bid(in1_bid),
        .in1_arvalid(in1_arvalid), .in1_araddr(in1_araddr), .in1_arid(in1_arid),
        .in1_arlen(in1_arlen), .in1_arsize(in1_arsize), .in1_arburst(in1_arburst),
        .in1_arready(in1_arready), .in1_rready(in1_rready), .in1_rvalid(in1_rvalid),
        .in1_rdata(in1_rdata), .in1_rresp(in1_rresp), .in1_rlast(in1_rlast), .in1_rid(in1_rid),
        .out_awvalid(out_awvalid), .out_awaddr(out_awaddr), .out_awid(out_awid),
        .out_awlen(out_awlen), .out_awsize(out_awsize), .out_awburst(out_awburst),
        .out_awready(out_awready), .out_wvalid(out_wvalid), .out_wdata(out_wdata),
        .out_wstrb(out_wstrb), .out_wlast(out_wlast), .out_wready(out_wready),
        .out_bready(out_bready), .out_bvalid(out_bvalid), .out_bresp(out_bresp), .out_bid(out_bid),
        .out_arvalid(out_arvalid), .out_araddr(out_araddr), .out_arid(out_arid),
        .out_arlen(out_arlen), .out_arsize(out_arsize), .out_arburst(out_arburst),
        .out_arready(out_arready), .out_rready(out_rready), .out_rvalid(out_rvalid),
        .out_rdata(out_rdata), .out_rresp(out_rresp), .out_rlast(out_rlast), .out_rid(out_rid)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // stim: [17:12] in0 {awvalid,wvalid,wlast,arvalid,rready,bready}, [11:6] in1 same,
    //       [5:0] slave {awready,wready,arready,rvalid,rlast,bvalid}
    typedef struct {
        logic [17:0] stim;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[18];

    function automatic logic [14:0] hs_vec();
        return {out_awvalid, out_wvalid, out_arvalid, out_rready, out_bready,
                in0_awready, in0_wready, in0_arready, in0_rvalid, in0_bvalid,
                in1_awready, in1_wready, in1_arready, in1_rvalid, in1_bvalid};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [17:0] s);
        {in0_awvalid, in0_wvalid, in0_wlast, in0_arvalid, in0_rready, in0_bready} = s[17:12];
        {in1_awvalid, in1_wvalid, in1_wlast, in1_arvalid, in1_rready, in1_bready} = s[11:6];
        {out_awready, out_wready, out_arready, out_rvalid, out_rlast, out_bvalid} = s[5:0];
    endtask

    task automatic clear_inputs();
        apply('0);
        in0_awaddr = '0; in0_awid = '0; in0_awlen = '0; in0_awsize = 3'd3; in0_awburst = 2'd1;
        in0_araddr = '0; in0_arid = '0; in0_arlen = '0; in0_arsize = 3'd3; in0_arburst = 2'd1;
        in0_wdata = '0; in0_wstrb = '0;
        in1_awaddr = '0; in1_awid = '0; in1_awlen = '0; in1_awsize = 3'd3; in1_awburst = 2'd1;
        in1_araddr = '0; in1_arid = '0; in1_arlen = '0; in1_arsize = 3'd3; in1_arburst = 2'd1;
        in1_wdata = '0; in1_wstrb = '0;
        out_bresp = '0; out_bid = '0; out_rdata = '0; out_rresp = '0; out_rid = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        clear_inputs();
        @(posedge clock);
        @(negedge clock);
        check("hs_during_reset", 64'(hs_vec()), 64'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Acts as the SDRAM slave for one single-beat transaction; slot is taken from
    // the forwarded ID (bench sets ID = slot number). Returns -1 if nothing appears.
    task automatic serve(output int slot, input bit keep_in1_aw);
        logic [ID_W-1:0] id;
        bit found = 0;
        slot = -1;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clock);
            #1;
            if (out_arvalid || out_awvalid) found = 1;
        end
        if (!found) return;
        if (out_arvalid) begin
            id = out_arid;
            slot = int'(id[1:0]);
            out_arready = 1'b1;
            @(posedge clock);
            @(negedge clock);
            out_arready = 1'b0;
            if (slot >= 2) in1_arvalid = 1'b0; else in0_arvalid = 1'b0;
            out_rvalid = 1'b1; out_rlast = 1'b1; out_rid = id;
            @(posedge clock);
            @(negedge clock);
            out_rvalid = 1'b0; out_rlast = 1'b0;
        end else begin
            id = out_awid;
            slot = int'(id[1:0]);
            out_awready = 1'b1;
            @(posedge clock);
            @(negedge clock);
            out_awready = 1'b0;
            if (slot >= 2) begin
                if (!keep_in1_aw) in1_awvalid = 1'b0;
                in1_wvalid = 1'b1; in1_wlast = 1'b1;
            end else begin
                in0_awvalid = 1'b0;
                in0_wvalid = 1'b1; in0_wlast = 1'b1;
            end
            out_wready = 1'b1;
            @(posedge clock);
            @(negedge clock);
            in0_wvalid = 1'b0; in0_wlast = 1'b0; in1_wvalid = 1'b0; in1_wlast = 1'b0;
            out_wready = 1'b0;
            out_bvalid = 1'b1; out_bid = id; out_bresp = 2'd0;
            @(posedge clock);
            @(negedge clock);
            out_bvalid = 1'b0;
        end
    endtask

    initial begin
        int slot;
        int writes;
        logic [63:0] beat;

        reset = 1'b1;
        clear_inputs();

        // ---------------- reset, then idle for 20 cycles
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            #1;
            check($sformatf("idle_hs_%0d", i), 64'(hs_vec()), 64'd0);
        end

        // ---------------- cycle-vector table (rr = 0 at start)
        vecs[0]  = '{{6'b000000, 6'b000000, 6'b000000}, 15'b00000_00000_00000};
        vecs[1]  = '{{6'b000100, 6'b000000, 6'b000000}, 15'b00000_00000_00000}; // S1 wins, rr=2
        vecs[2]  = '{{6'b000100, 6'b000000, 6'b001000}, 15'b00100_00100_00000};
        vecs[3]  = '{{6'b000010, 6'b000000, 6'b000000}, 15'b00010_00000_00000};
        vecs[4]  = '{{6'b000010, 6'b000000, 6'b000110}, 15'b00010_00010_00000};
        vecs[5]  = '{{6'b000000, 6'b000000, 6'b000000}, 15'b00000_00000_00000};
        vecs[6]  = '{{6'b100000, 6'b000100, 6'b000000}, 15'b00000_00000_00000}; // S3 beats S0, rr=0
        vecs[7]  = '{{6'b100000, 6'b000100, 6'b000000}, 15'b00100_00000_00000};
        vecs[8]  = '{{6'b100000, 6'b000100, 6'b001000}, 15'b00100_00000_00100};
        vecs[9]  = '{{6'b100000, 6'b000000, 6'b000100}, 15'b00000_00000_00010};
        vecs[10] = '{{6'b100000, 6'b000010, 6'b000110}, 15'b00010_00000_00010};
        vecs[11] = '{{6'b100000, 6'b000000, 6'b000000}, 15'b00000_00000_00000}; // S0 wins
        vecs[12] = '{{6'b111000, 6'b000000, 6'b110000}, 15'b10000_10000_00000}; // no W before AW
        vecs[13] = '{{6'b010000, 6'b000000, 6'b010000}, 15'b01000_01000_00000};
        vecs[14] = '{{6'b011000, 6'b000000, 6'b010000}, 15'b01000_01000_00000};
        vecs[15] = '{{6'b000000, 6'b000000, 6'b000001}, 15'b00000_00001_00000};
        vecs[16] = '{{6'b000001, 6'b000000, 6'b000001}, 15'b00001_00001_00000};
        vecs[17] = '{{6'b000000, 6'b000000, 6'b000000}, 15'b00000_00000_00000};
        for (int i = 0; i < 18; i++) begin
            @(negedge clock);
            apply(vecs[i].stim);
            #1;
            check($sformatf("vec%0d", i), 64'(hs_vec()), 64'(vecs[i].exp));
        end
        @(negedge clock);
        apply('0);

        // ---------------- in0 single read with payload routing
        @(negedge clock);
        in0_araddr = 32'hA000_0000; in0_arlen = 8'd0; in0_arid = 4'h1; in0_arvalid = 1'b1;
        in0_rready = 1'b1; in1_rready = 1'b1;
        #1;
        check("rd_idle_arvalid", 64'(out_arvalid), 64'd0);
        @(negedge clock);
        #1;
        check("rd_arvalid_t1", 64'(out_arvalid), 64'd1);
        check("rd_araddr", 64'(out_araddr), 64'hA000_0000);
        check("rd_arlen", 64'(out_arlen), 64'd0);
        out_arready = 1'b1;
        @(negedge clock);
        out_arready = 1'b0; in0_arvalid = 1'b0;
        out_rvalid = 1'b1; out_rlast = 1'b1; out_rdata = 64'h1122_3344_5566_7788; out_rid = 4'h1;
        #1;
        check("rd_in0_rvalid", 64'(in0_rvalid), 64'd1);
        check("rd_in0_rdata", in0_rdata, 64'h1122_3344_5566_7788);
        check("rd_in1_rvalid", 64'(in1_rvalid), 64'd0);
        @(negedge clock);
        out_rvalid = 1'b0; out_rlast = 1'b0;
        #1;
        check("rd_done_idle", 64'(hs_vec()), 64'd0);
        in0_rready = 1'b0; in1_rready = 1'b0;

        // ---------------- in1 4-beat write
        @(negedge clock);
        in1_awvalid = 1'b1; in1_awaddr = 32'h0000_1000; in1_awlen = 8'd3; in1_awid = 4'h5;
        in1_wvalid = 1'b1; in1_wstrb = 8'hFF; in1_wdata = 64'h0; in1_wlast = 1'b0;
        @(negedge clock);
        #1;
        check("wr_awvalid", 64'(out_awvalid), 64'd1);
        check("wr_awlen", 64'(out_awlen), 64'd3);
        check("wr_no_w_before_aw", 64'(out_wvalid), 64'd0);
        out_awready = 1'b1; out_wready = 1'b1;
        @(negedge clock);
        out_awready = 1'b0; in1_awvalid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            beat = {32'hCAFE_0000 + 32'(b), 32'h0000_BEEF};
            in1_wdata = beat; in1_wlast = (b == 3);
            #1;
            check($sformatf("wr_wvalid_%0d", b), 64'(out_wvalid), 64'd1);
            check($sformatf("wr_wdata_%0d", b), out_wdata, beat);
            check($sformatf("wr_wstrb_%0d", b), 64'(out_wstrb), 64'hFF);
            @(negedge clock);
        end
        in1_wvalid = 1'b0; in1_wlast = 1'b0; out_wready = 1'b0;
        out_bvalid = 1'b1; out_bresp = 2'd0; out_bid = 4'h5; in1_bready = 1'b1;
        #1;
        check("wr_in1_bvalid", 64'(in1_bvalid), 64'd1);
        check("wr_in1_bid", 64'(in1_bid), 64'h5);
        check("wr_in1_bresp", 64'(in1_bresp), 64'd0);
        check("wr_in0_bvalid", 64'(in0_bvalid), 64'd0);
        @(negedge clock);
        out_bvalid = 1'b0; in1_bready = 1'b0;
        #1;
        check("wr_done_idle", 64'(hs_vec()), 64'd0);

        // ---------------- all four slots at once from reset
        do_reset();
        in0_awid = 4'd0; in0_arid = 4'd1; in1_awid = 4'd2; in1_arid = 4'd3;
        in0_rready = 1'b1; in0_bready = 1'b1; in1_rready = 1'b1; in1_bready = 1'b1;
        in0_awvalid = 1'b1; in0_arvalid = 1'b1; in1_awvalid = 1'b1; in1_arvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            serve(slot, 1'b0);
            check($sformatf("grant_order_%0d", k), 64'(slot), 64'(k));
        end
        check("rr_wrapped", 64'(dut.rr), 64'd0);

        // ---------------- in0 AR held against back-to-back in1 writes
        in0_arvalid = 1'b1;
        serve(slot, 1'b0);
        check("fair_setup_rd", 64'(slot), 64'd1);
        in0_arvalid = 1'b1; in1_awvalid = 1'b1;
        writes = 0;
        for (int k = 0; k < 3; k++) begin
            serve(slot, 1'b1);
            if (slot == 2) writes++;
            if (slot != 2) break;
        end
        in1_awvalid = 1'b0;
        check("fair_read_slot", 64'(slot), 64'd1);
        check("fair_writes_before_read", 64'(writes), 64'd1);

        // ---------------- reset during an 8-beat read
        @(negedge clock);
        in0_arvalid = 1'b1; in0_arlen = 8'd7; in0_arid = 4'd1;
        @(negedge clock);
        #1;
        check("rst_arvalid", 64'(out_arvalid), 64'd1);
        out_arready = 1'b1;
        @(negedge clock);
        out_arready = 1'b0; in0_arvalid = 1'b0;
        out_rvalid = 1'b1; out_rlast = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("rst_mid_rvalid", 64'(in0_rvalid), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        #1;
        check("rst_hs_zero", 64'(hs_vec()), 64'd0);
        out_rvalid = 1'b0;
        reset = 1'b0;
        in0_arlen = 8'd0;
        in0_arvalid = 1'b1;
        serve(slot, 1'b0);
        check("rst_new_read", 64'(slot), 64'd1);
        #1;
        check("rst_final_idle", 64'(hs_vec()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_axi_arbiter.md
# sdram_axi_arbiter

Two-master AXI4 arbiter that shares the single SDRAM AXI slave port (64-bit data, 32-bit address, 4-bit ID) between two upstream masters, for example the CPU data port and a DMA engine. It grants one whole transaction at a time, read or write, using round-robin priority, and routes the response back to the granted master. It sits directly in front of the SDRAM top-level AXI port. It adds no buffering; all payloads pass through combinationally under the current grant.

## Interface
- ADDR_W, 32, address width on all AW/AR channels
- DATA_W, 64, R/W data width; strobe width is DATA_W/8
- ID_W, 4, AXI ID width; IDs pass through unmodified
- clock  in  1  single clock for all ports
- reset  in  1  synchronous, active-high
- in<n>_aw{valid,addr,id,len,size,burst}  in  1/ADDR_W/ID_W/8/3/2  write address from master n (n=0,1)
- in<n>_awready  out  1  write address accept to master n
- in<n>_w{valid,data,strb,last}  in  1/DATA_W/DATA_W/8/1  write data from master n
- in<n>_wready  out  1  write data accept
- in<n>_bready  in  1  write response accept
- in<n>_b{valid,resp,id}  out  1/2/ID_W  write response to master n
- in<n>_ar{valid,addr,id,len,size,burst}  in  1/ADDR_W/ID_W/8/3/2  read address from master n
- in<n>_arready  out  1  read address accept
- in<n>_rready  in  1  read data accept
- in<n>_r{valid,data,resp,last,id}  out  1/DATA_W/2/1/ID_W  read data to master n
- out_aw*, out_w*, out_ar*, out_bready, out_rready  out  as above  master-side port to SDRAM slave
- out_awready, out_wready, out_arready, out_b*, out_r*  in  as above  slave responses

## Operation
- Request slots, in round-robin order: S0=in0 AW, S1=in0 AR, S2=in1 AW, S3=in1 AR. A slot is requesting when its valid is high.
- Round-robin pointer rr[1:0] names the highest-priority slot. The search order is rr, rr+1, rr+2, rr+3 (mod 4). After each grant, rr becomes winner+1 (mod 4).
- FSM states: IDLE, AR_FWD, R_DATA, AW_FWD, W_DATA, B_RESP.
- IDLE: if any slot requests, register grant (master index, rd/wr) and update rr.
  - A read grant goes to AR_FWD; a write grant goes to AW_FWD.
  - With no request, stay in IDLE.
- AR_FWD: out_arvalid = granted ar valid; AR payload muxed from the granted master; granted arready = out_arready. Leave for R_DATA on the AR handshake.
- R_DATA: out_r payload is broadcast to both masters. Granted rvalid = out_rvalid; out_rready = granted rready. Leave for IDLE on an R handshake with rlast=1.
- AW_FWD: forwarding as in AR_FWD. Leave for W_DATA on the AW handshake.
- W_DATA: forward W from the granted master. Leave for B_RESP on a W handshake with wlast=1. W is never forwarded before the AW handshake.
- B_RESP: forward B. Leave for IDLE on the B handshake.
- Non-granted masters see every ready and valid output at 0. All out_*valid/ready outputs are 0 outside their state.
- Payload fields (addr, data, id, resp, len, size, burst, strb, last) are unconstrained while the matching valid is 0. Downstream sees granted payload even when that valid is 0.
- Resp and ID pass through unchanged; the arbiter never generates responses.

## Timing
- Reset state: FSM=IDLE, rr=0 (S0 highest), grant cleared. All outputs whose name ends in valid or ready are 0 during and after reset until the first grant.
- Arbitration latency: a request seen in IDLE at cycle t is forwarded downstream at t+1.
- Throughput: at least one IDLE cycle between consecutive transactions.
- Ready/valid paths are combinational through the FSM state, with no added register stage inside a burst.
- Simultaneous requests in IDLE: exactly one winner per the rr order. Losers keep valid asserted and are served later, with no starvation. Each slot waits at most 3 transactions.
- A master asserting both AW and AR is treated as two independent slots.
- Reset mid-transaction returns the FSM to IDLE next cycle. The SDRAM slave shares this reset, so no in-flight burst survives.
- A valid dropped before its handshake is an AXI protocol violation; behaviour is undefined and not checked.

## Test plan
- Reset, then no traffic -> all *ready/*valid outputs 0, FSM IDLE for 20 cycles.
- in0 single read: araddr=0xA0000000, arlen=0 -> out_arvalid at cycle+1. Slave returns rdata=0x1122334455667788 with rlast=1 -> in0_rvalid with that data; in1_rvalid stays 0.
- in1 4-beat write: awlen=3, 4 W beats with wstrb=0xFF -> out_wvalid only after the AW handshake; 4 beats in order; in1_bvalid with bresp=0 and bid=in1_awid.
- All four slots request simultaneously from reset -> grant order S0, S1, S2, S3; rr returns to 0.
- in0 AR held continuously while in1 issues back-to-back writes -> in0 read granted no later than the 2nd in1 write.
- Assert reset during R_DATA of an 8-beat read -> FSM IDLE the next cycle; all valid/ready outputs 0; a new read completes normally afterwards.
